// File: rtl/pipelined_memory_unit.sv
// Unified word-addressed RAM: valid/ready request port, byte-enable writes, fixed-latency in-order responses.
// Define MEMORY_BOOT_EN to preload the five-word demo program at BOOT_BASE after every reset.
module pipelined_memory_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BOOT_BASE  = 105
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W  = ADDR_W + 1;
  localparam int unsigned BOOT_N = 5;

  if ((BOOT_BASE + BOOT_N > DEPTH) || (RD_LATENCY < 1) || (RD_LATENCY > 4)
      || (DATA_W % 8 != 0)) begin : g_bad_params
    $error("pipelined_memory_unit: illegal parameter combination");
  end

`ifdef MEMORY_BOOT_EN
  typedef enum logic {ST_INIT, ST_READY} state_e;
  localparam state_e ST_RESET = ST_INIT;
  localparam logic [31:0] BOOT_ROM [BOOT_N] = '{
    32'h0000_0005, 32'h0000_0004, 32'h2002_0069, 32'h2003_006A, 32'h0043_2000
  };
  logic [2:0]        cnt_q, cnt_d;
  logic              boot_we_c;
  logic [IDX_W-1:0]  boot_idx_c;
  logic [DATA_W-1:0] boot_wdata_c;
`else
  typedef enum logic {ST_READY} state_e;
  localparam state_e ST_RESET = ST_READY;
`endif

  state_e state_q, state_d;
  logic   ready_q, ready_d;
  logic   done_q, done_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept_c;
  logic              in_range_c;
  logic              wr_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] rd_word_c;

  // Full-width unsigned compare so high address bits never alias into the array.
  assign accept_c   = req_valid && ready_q;
  assign in_range_c = (CMP_W'(req_addr) < CMP_W'(DEPTH));
  assign idx_c      = req_addr[IDX_W-1:0];
  assign wr_c       = accept_c && req_write && in_range_c;
  assign rd_word_c  = mem_q[idx_c];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEMORY_BOOT_EN
      cnt_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef MEMORY_BOOT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state: boot walks the table one word per cycle, then READY opens the port.
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
`ifdef MEMORY_BOOT_EN
    cnt_d        = cnt_q;
    boot_we_c    = 1'b0;
    boot_idx_c   = IDX_W'(BOOT_BASE) + IDX_W'(cnt_q);
    boot_wdata_c = DATA_W'(BOOT_ROM[cnt_q]);
`endif
    case (state_q)
`ifdef MEMORY_BOOT_EN
      ST_INIT: begin
        boot_we_c = 1'b1;
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'(BOOT_N - 1)) begin
          state_d = ST_READY;
          cnt_d   = 3'd0;
        end
      end
`endif
      ST_READY: begin
        ready_d = 1'b1;
        done_d  = 1'b1;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // RAM array is deliberately not reset so non-boot contents survive a reset.
  always_ff @(posedge clk) begin
`ifdef MEMORY_BOOT_EN
    if (boot_we_c) mem_q[boot_idx_c] <= boot_wdata_c;
`endif
    if (wr_c) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (req_be[b]) mem_q[idx_c][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  logic [RD_LATENCY-1:0] pv_q;
  logic [RD_LATENCY-1:0] pe_q;
  logic [DATA_W-1:0]     pd_q [RD_LATENCY];

  // Response shift pipeline; data is zero for writes, errors and empty slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= accept_c;
      pe_q[0] <= accept_c && !in_range_c;
      pd_q[0] <= (accept_c && !req_write && in_range_c) ? rd_word_c : '0;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign req_ready = ready_q;
  assign init_done = done_q;
  assign rsp_valid = pv_q[RD_LATENCY-1];
  assign rsp_err   = pe_q[RD_LATENCY-1];
  assign rsp_rdata = pd_q[RD_LATENCY-1];

endmodule

// File: tb/tb_pipelined_memory_unit.sv
// Scoreboard bench for pipelined_memory_unit: random traffic against a word-array reference model.
// Expectations follow MEMORY_BOOT_EN the same way the design does.
module tb_pipelined_memory_unit;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 3;
  localparam int unsigned BB    = 105;
`ifdef MEMORY_BOOT_EN
  localparam bit          BOOT     = 1'b1;
  localparam int unsigned INIT_CYC = 6;
`else
  localparam bit          BOOT     = 1'b0;
  localparam int unsigned INIT_CYC = 1;
`endif

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          init_done;

  pipelined_memory_unit #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LATENCY(LAT), .BOOT_BASE(BB)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    logic        err;
    bit          chk;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl   [DEPTH];
  bit          known [DEPTH];
  int unsigned cyc;
  int          n_tests;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reset discards in-flight responses; boot (if present) rewrites its five words.
  function automatic void model_reset();
    logic [31:0] words [5];
    words = '{32'h5, 32'h4, 32'h2002_0069, 32'h2003_006A, 32'h0043_2000};
    sb.delete();
    if (BOOT) begin
      for (int i = 0; i < 5; i++) begin
        mdl[BB + i]   = words[i];
        known[BB + i] = 1'b1;
      end
    end
  endfunction

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    int   idx;
    check("req_ready_at_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
    e.cyc  = cyc + LAT;
    e.err  = (a >= DEPTH);
    e.data = 32'h0;
    e.chk  = 1'b1;
    if (!e.err) begin
      idx = int'(a);
      if (wr) begin
        for (int b = 0; b < 4; b++) if (be[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        known[idx] = known[idx] || (be == 4'hF);
      end else begin
        e.data = mdl[idx];
        e.chk  = known[idx];
      end
    end
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic wait_init();
    int k = 0;
    while (!init_done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("init_cycles", 32'(k), 32'(INIT_CYC));
    check("init_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("rsp_cycle", cyc, e.cyc);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          if (e.chk) check("rsp_rdata", rsp_rdata, e.data);
        end
      end else begin
        check("idle_rdata", rsp_rdata, 32'h0);
        check("idle_err", 32'(rsp_err), 32'h0);
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_missing: got no response expected one at cycle %0d", sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  endtask

  initial begin
    int unsigned r;
    logic [31:0] a;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);

    model_reset();
    reset = 1'b0;
    wait_init();

    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i), $urandom, 4'hF);
    for (int i = 0; i < 5; i++) issue(1'b0, 32'(BB + i), 32'h0, 4'h0);

    // Byte-enable merge on address 10, then a be=0 no-op write.
    issue(1'b1, 32'd10, 32'hAABB_CCDD, 4'b1111);
    issue(1'b1, 32'd10, 32'h1122_3344, 4'b0101);
    issue(1'b0, 32'd10, 32'h0, 4'h0);
    check("be_merge_model", mdl[10], 32'hAA22_CC44);
    issue(1'b1, 32'd11, 32'hDEAD_BEEF, 4'b0000);
    issue(1'b0, 32'd11, 32'h0, 4'h0);

    // Out-of-range accesses must neither write nor alias onto low addresses.
    issue(1'b1, 32'd256, 32'h0000_1234, 4'hF);
    issue(1'b0, 32'd256, 32'h0, 4'h0);
    issue(1'b0, 32'd0, 32'h0, 4'h0);
    issue(1'b1, 32'd258, 32'h5555_5555, 4'hF);
    issue(1'b0, 32'd2, 32'h0, 4'h0);
    issue(1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0);
    idle(); idle();

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(9, 0);
      if ($urandom_range(4, 0) == 0) begin
        idle();
      end else begin
        if (r < 7)       a = 32'($urandom_range(15, 0));
        else if (r == 7) a = 32'(BB + $urandom_range(4, 0));
        else if (r == 8) a = 32'(DEPTH + $urandom_range(40, 0));
        else             a = $urandom | 32'h8000_0000;
        issue($urandom_range(2, 0) == 0, a, $urandom, 4'($urandom));
      end
    end
    repeat (LAT + 2) idle();

    // Reset lands while a read is in flight; its response must never appear.
    issue(1'b0, 32'(BB), 32'h0, 4'h0);
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init();
    issue(1'b0, 32'(BB), 32'h0, 4'h0);
    for (int i = 0; i < 16; i++) issue(1'b0, 32'(i), 32'h0, 4'h0);

    for (int w = 0; w < LAT + 10 && sb.size() > 0; w++) idle();
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: got %0d outstanding responses expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
